// File: rtl/fifo_stream_checker.sv
// fifo_stream_checker
//   Read-side consumer for the dual-clock FIFO. Pops words and compares them
//   against an incrementing reference sequence (START_VALUE, +1, skipping zero
//   on wrap). Counts words and mismatches, captures the most recent mismatch,
//   and re-locks by adopting the word that follows an error.
//
// Ports:
//   clock             rising-edge clock
//   rst               synchronous active-high reset
//   start             one-cycle pulse, begins checking from IDLE
//   stop              one-cycle pulse, returns to IDLE from any state
//   throttle[3:0]     idle cycles forced between consecutive pops
//   fifo_data         FIFO read data
//   fifo_data_valid   FIFO has a word on fifo_data
//   fifo_data_ack     pop request (combinational)
//   word_count        words popped since start, saturating
//   error_count       mismatches since start, saturating
//   mismatch_expected expected value at most recent mismatch
//   mismatch_actual   received value at most recent mismatch
//   locked            high in RUN
//   busy              high in RUN or RESYNC
module fifo_stream_checker #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            COUNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]  START_VALUE = DATA_WIDTH'(1)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [3:0]             throttle,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_data_valid,
  output logic                   fifo_data_ack,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [DATA_WIDTH-1:0]  mismatch_expected,
  output logic [DATA_WIDTH-1:0]  mismatch_actual,
  output logic                   locked,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] expected;
  logic [3:0]            gap;
  logic                  pop;
  logic                  match;

  // Sequence successor: all-ones wraps to START_VALUE so zero never appears.
  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [DATA_WIDTH-1:0] x);
    return (x == '1) ? START_VALUE : x + DATA_WIDTH'(1);
  endfunction

  assign fifo_data_ack = ((state == RUN) || (state == RESYNC)) && (gap == 4'd0);
  assign pop           = fifo_data_valid && fifo_data_ack;
  assign match         = (fifo_data == expected);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)         state_next = RUN;
      RUN:     if (pop && !match) state_next = RESYNC;
      RESYNC:  if (pop)           state_next = RUN;
      default:                    state_next = IDLE;
    endcase
    // stop beats start and any pop-driven transition; the pop itself is
    // still accounted below.
    if (stop) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state             <= IDLE;
      expected          <= START_VALUE;
      gap               <= '0;
      word_count        <= '0;
      error_count       <= '0;
      mismatch_expected <= '0;
      mismatch_actual   <= '0;
      locked            <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state  <= state_next;
      // Status flags are registered copies of the next state.
      locked <= (state_next == RUN);
      busy   <= (state_next != IDLE);

      if (pop) begin
        gap <= throttle;
      end else if (gap != 4'd0) begin
        gap <= gap - 4'd1;
      end

      if ((state == IDLE) && start && !stop) begin
        expected          <= START_VALUE;
        word_count        <= '0;
        error_count       <= '0;
        mismatch_expected <= '0;
        mismatch_actual   <= '0;
      end

      // pop implies state is RUN or RESYNC, so this never collides with the
      // start-time clear above.
      if (pop) begin
        if (word_count != '1) word_count <= word_count + COUNT_WIDTH'(1);
        if (state == RESYNC) begin
          expected <= next_word(fifo_data);
        end else if (match) begin
          expected <= next_word(expected);
        end else begin
          if (error_count != '1) error_count <= error_count + COUNT_WIDTH'(1);
          mismatch_expected <= expected;
          mismatch_actual   <= fifo_data;
        end
      end
    end
  end

endmodule
